// File: rtl/ysyx_22050133_axi_router_pkg.sv
// Shared encodings for the AXI router: response codes, target selects, FSM states.
package ysyx_22050133_axi_router_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    SEL_M0  = 2'd0,
    SEL_M1  = 2'd1,
    SEL_ERR = 2'd2
  } sel_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_BUSY = 1'b1
  } rstate_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

endpackage

// File: rtl/ysyx_22050133_addr_decode.sv
// Combinational address-to-target decoder; the device window takes priority over memory.
module ysyx_22050133_addr_decode
  import ysyx_22050133_axi_router_pkg::*;
#(
  parameter int                 ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]  MEM_BASE = 64'h8000_0000,
  parameter logic [ADDR_W-1:0]  MEM_SIZE = 64'h0800_0000,
  parameter logic [ADDR_W-1:0]  DEV_BASE = 64'h0200_0000,
  parameter logic [ADDR_W-1:0]  DEV_SIZE = 64'h0001_0000
) (
  input  logic [ADDR_W-1:0] i_addr,
  output sel_e              o_sel
);

  logic [ADDR_W-1:0] w_off_mem;
  logic [ADDR_W-1:0] w_off_dev;
  logic              w_hit_mem;
  logic              w_hit_dev;

  // Offset-then-compare keeps windows near the top of the address space from wrapping.
  assign w_off_mem = i_addr - MEM_BASE;
  assign w_off_dev = i_addr - DEV_BASE;
  assign w_hit_mem = (i_addr >= MEM_BASE) && (w_off_mem < MEM_SIZE);
  assign w_hit_dev = (i_addr >= DEV_BASE) && (w_off_dev < DEV_SIZE);

  always_comb begin
    if (w_hit_dev)      o_sel = SEL_M1;
    else if (w_hit_mem) o_sel = SEL_M0;
    else                o_sel = SEL_ERR;
  end

endmodule

// File: rtl/ysyx_22050133_axi_router.sv
// 1-to-2 AXI router (m0 = memory, m1 = device) with internal DECERR responder.
// Read and write paths each hold one outstanding transaction, routed at the address handshake.
module ysyx_22050133_axi_router
  import ysyx_22050133_axi_router_pkg::*;
#(
  parameter int                         AXI_DATA_WIDTH = 64,
  parameter int                         AXI_ADDR_WIDTH = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0]  MEM_BASE       = 64'h8000_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0]  MEM_SIZE       = 64'h0800_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0]  DEV_BASE       = 64'h0200_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0]  DEV_SIZE       = 64'h0001_0000
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic                          s_axi_aw_valid_i,
  output logic                          s_axi_aw_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_aw_addr_i,
  input  logic                          s_axi_w_valid_i,
  output logic                          s_axi_w_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_w_strb_i,
  input  logic                          s_axi_b_ready_i,
  output logic                          s_axi_b_valid_o,
  output logic [1:0]                    s_axi_b_resp_o,
  input  logic                          s_axi_ar_valid_i,
  output logic                          s_axi_ar_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_ar_addr_i,
  input  logic                          s_axi_r_ready_i,
  output logic                          s_axi_r_valid_o,
  output logic [1:0]                    s_axi_r_resp_o,
  output logic [AXI_DATA_WIDTH-1:0]     s_axi_r_data_o,

  input  logic                          m0_axi_aw_ready_i,
  output logic                          m0_axi_aw_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]     m0_axi_aw_addr_o,
  input  logic                          m0_axi_w_ready_i,
  output logic                          m0_axi_w_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]     m0_axi_w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   m0_axi_w_strb_o,
  output logic                          m0_axi_b_ready_o,
  input  logic                          m0_axi_b_valid_i,
  input  logic [1:0]                    m0_axi_b_resp_i,
  input  logic                          m0_axi_ar_ready_i,
  output logic                          m0_axi_ar_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]     m0_axi_ar_addr_o,
  output logic                          m0_axi_r_ready_o,
  input  logic                          m0_axi_r_valid_i,
  input  logic [1:0]                    m0_axi_r_resp_i,
  input  logic [AXI_DATA_WIDTH-1:0]     m0_axi_r_data_i,

  input  logic                          m1_axi_aw_ready_i,
  output logic                          m1_axi_aw_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]     m1_axi_aw_addr_o,
  input  logic                          m1_axi_w_ready_i,
  output logic                          m1_axi_w_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]     m1_axi_w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   m1_axi_w_strb_o,
  output logic                          m1_axi_b_ready_o,
  input  logic                          m1_axi_b_valid_i,
  input  logic [1:0]                    m1_axi_b_resp_i,
  input  logic                          m1_axi_ar_ready_i,
  output logic                          m1_axi_ar_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]     m1_axi_ar_addr_o,
  output logic                          m1_axi_r_ready_o,
  input  logic                          m1_axi_r_valid_i,
  input  logic [1:0]                    m1_axi_r_resp_i,
  input  logic [AXI_DATA_WIDTH-1:0]     m1_axi_r_data_i
);

  rstate_e r_rstate;
  sel_e    r_rsel;
  wstate_e r_wstate;
  sel_e    r_wsel;
  sel_e    w_ar_sel;
  sel_e    w_aw_sel;

  ysyx_22050133_addr_decode #(
    .ADDR_W   (AXI_ADDR_WIDTH),
    .MEM_BASE (MEM_BASE),
    .MEM_SIZE (MEM_SIZE),
    .DEV_BASE (DEV_BASE),
    .DEV_SIZE (DEV_SIZE)
  ) u_ar_decode (
    .i_addr (s_axi_ar_addr_i),
    .o_sel  (w_ar_sel)
  );

  ysyx_22050133_addr_decode #(
    .ADDR_W   (AXI_ADDR_WIDTH),
    .MEM_BASE (MEM_BASE),
    .MEM_SIZE (MEM_SIZE),
    .DEV_BASE (DEV_BASE),
    .DEV_SIZE (DEV_SIZE)
  ) u_aw_decode (
    .i_addr (s_axi_aw_addr_i),
    .o_sel  (w_aw_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rsel   <= SEL_M0;
    end else begin
      case (r_rstate)
        R_IDLE: if (s_axi_ar_valid_i && s_axi_ar_ready_o) begin
          r_rsel   <= w_ar_sel;
          r_rstate <= R_BUSY;
        end
        R_BUSY: if (s_axi_r_valid_o && s_axi_r_ready_i) r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_wsel   <= SEL_M0;
    end else begin
      case (r_wstate)
        W_IDLE: if (s_axi_aw_valid_i && s_axi_aw_ready_o) begin
          r_wsel   <= w_aw_sel;
          r_wstate <= W_DATA;
        end
        W_DATA: if (s_axi_w_valid_i && s_axi_w_ready_o) r_wstate <= W_RESP;
        W_RESP: if (s_axi_b_valid_o && s_axi_b_ready_i) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read path: pure combinational steering; everything is forced low while in reset.
  always_comb begin
    s_axi_ar_ready_o  = 1'b0;
    m0_axi_ar_valid_o = 1'b0;
    m1_axi_ar_valid_o = 1'b0;
    m0_axi_ar_addr_o  = '0;
    m1_axi_ar_addr_o  = '0;
    s_axi_r_valid_o   = 1'b0;
    s_axi_r_resp_o    = RESP_OKAY;
    s_axi_r_data_o    = '0;
    m0_axi_r_ready_o  = 1'b0;
    m1_axi_r_ready_o  = 1'b0;
    if (!rst) begin
      m0_axi_ar_addr_o = s_axi_ar_addr_i;
      m1_axi_ar_addr_o = s_axi_ar_addr_i;
      case (r_rstate)
        R_IDLE: begin
          case (w_ar_sel)
            SEL_M0: begin
              m0_axi_ar_valid_o = s_axi_ar_valid_i;
              s_axi_ar_ready_o  = m0_axi_ar_ready_i;
            end
            SEL_M1: begin
              m1_axi_ar_valid_o = s_axi_ar_valid_i;
              s_axi_ar_ready_o  = m1_axi_ar_ready_i;
            end
            SEL_ERR: s_axi_ar_ready_o = 1'b1;
            default: ;
          endcase
        end
        R_BUSY: begin
          case (r_rsel)
            SEL_M0: begin
              s_axi_r_valid_o  = m0_axi_r_valid_i;
              s_axi_r_resp_o   = m0_axi_r_resp_i;
              s_axi_r_data_o   = m0_axi_r_data_i;
              m0_axi_r_ready_o = s_axi_r_ready_i;
            end
            SEL_M1: begin
              s_axi_r_valid_o  = m1_axi_r_valid_i;
              s_axi_r_resp_o   = m1_axi_r_resp_i;
              s_axi_r_data_o   = m1_axi_r_data_i;
              m1_axi_r_ready_o = s_axi_r_ready_i;
            end
            SEL_ERR: begin
              s_axi_r_valid_o = 1'b1;
              s_axi_r_resp_o  = RESP_DECERR;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_axi_aw_ready_o  = 1'b0;
    m0_axi_aw_valid_o = 1'b0;
    m1_axi_aw_valid_o = 1'b0;
    m0_axi_aw_addr_o  = '0;
    m1_axi_aw_addr_o  = '0;
    s_axi_w_ready_o   = 1'b0;
    m0_axi_w_valid_o  = 1'b0;
    m1_axi_w_valid_o  = 1'b0;
    m0_axi_w_data_o   = '0;
    m1_axi_w_data_o   = '0;
    m0_axi_w_strb_o   = '0;
    m1_axi_w_strb_o   = '0;
    s_axi_b_valid_o   = 1'b0;
    s_axi_b_resp_o    = RESP_OKAY;
    m0_axi_b_ready_o  = 1'b0;
    m1_axi_b_ready_o  = 1'b0;
    if (!rst) begin
      m0_axi_aw_addr_o = s_axi_aw_addr_i;
      m1_axi_aw_addr_o = s_axi_aw_addr_i;
      case (r_wstate)
        W_IDLE: begin
          case (w_aw_sel)
            SEL_M0: begin
              m0_axi_aw_valid_o = s_axi_aw_valid_i;
              s_axi_aw_ready_o  = m0_axi_aw_ready_i;
            end
            SEL_M1: begin
              m1_axi_aw_valid_o = s_axi_aw_valid_i;
              s_axi_aw_ready_o  = m1_axi_aw_ready_i;
            end
            SEL_ERR: s_axi_aw_ready_o = 1'b1;
            default: ;
          endcase
        end
        W_DATA: begin
          case (r_wsel)
            SEL_M0: begin
              m0_axi_w_valid_o = s_axi_w_valid_i;
              m0_axi_w_data_o  = s_axi_w_data_i;
              m0_axi_w_strb_o  = s_axi_w_strb_i;
              s_axi_w_ready_o  = m0_axi_w_ready_i;
            end
            SEL_M1: begin
              m1_axi_w_valid_o = s_axi_w_valid_i;
              m1_axi_w_data_o  = s_axi_w_data_i;
              m1_axi_w_strb_o  = s_axi_w_strb_i;
              s_axi_w_ready_o  = m1_axi_w_ready_i;
            end
            SEL_ERR: s_axi_w_ready_o = 1'b1;
            default: ;
          endcase
        end
        W_RESP: begin
          case (r_wsel)
            SEL_M0: begin
              s_axi_b_valid_o  = m0_axi_b_valid_i;
              s_axi_b_resp_o   = m0_axi_b_resp_i;
              m0_axi_b_ready_o = s_axi_b_ready_i;
            end
            SEL_M1: begin
              s_axi_b_valid_o  = m1_axi_b_valid_i;
              s_axi_b_resp_o   = m1_axi_b_resp_i;
              m1_axi_b_ready_o = s_axi_b_ready_i;
            end
            SEL_ERR: begin
              s_axi_b_valid_o = 1'b1;
              s_axi_b_resp_o  = RESP_DECERR;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_axi_router.sv
// Directed bench for the AXI router: per-step assertions plus a queue of expected R/B responses.
module tb_ysyx_22050133_axi_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_ready, s_b_valid;
  logic        s_ar_valid, s_ar_ready, s_r_ready, s_r_valid;
  logic [63:0] s_aw_addr, s_ar_addr, s_w_data, s_r_data;
  logic [7:0]  s_w_strb;
  logic [1:0]  s_b_resp, s_r_resp;

  logic        m0_aw_ready, m0_aw_valid, m0_w_ready, m0_w_valid, m0_b_ready, m0_b_valid;
  logic        m0_ar_ready, m0_ar_valid, m0_r_ready, m0_r_valid;
  logic [63:0] m0_aw_addr, m0_ar_addr, m0_w_data, m0_r_data;
  logic [7:0]  m0_w_strb;
  logic [1:0]  m0_b_resp, m0_r_resp;

  logic        m1_aw_ready, m1_aw_valid, m1_w_ready, m1_w_valid, m1_b_ready, m1_b_valid;
  logic        m1_ar_ready, m1_ar_valid, m1_r_ready, m1_r_valid;
  logic [63:0] m1_aw_addr, m1_ar_addr, m1_w_data, m1_r_data;
  logic [7:0]  m1_w_strb;
  logic [1:0]  m1_b_resp, m1_r_resp;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
  } rbeat_t;

  rbeat_t     exp_r_q[$];
  logic [1:0] exp_b_q[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  ysyx_22050133_axi_router dut (
    .clk(clk), .rst(rst),
    .s_axi_aw_valid_i(s_aw_valid), .s_axi_aw_ready_o(s_aw_ready), .s_axi_aw_addr_i(s_aw_addr),
    .s_axi_w_valid_i(s_w_valid), .s_axi_w_ready_o(s_w_ready), .s_axi_w_data_i(s_w_data),
    .s_axi_w_strb_i(s_w_strb),
    .s_axi_b_ready_i(s_b_ready), .s_axi_b_valid_o(s_b_valid), .s_axi_b_resp_o(s_b_resp),
    .s_axi_ar_valid_i(s_ar_valid), .s_axi_ar_ready_o(s_ar_ready), .s_axi_ar_addr_i(s_ar_addr),
    .s_axi_r_ready_i(s_r_ready), .s_axi_r_valid_o(s_r_valid), .s_axi_r_resp_o(s_r_resp),
    .s_axi_r_data_o(s_r_data),
    .m0_axi_aw_ready_i(m0_aw_ready), .m0_axi_aw_valid_o(m0_aw_valid), .m0_axi_aw_addr_o(m0_aw_addr),
    .m0_axi_w_ready_i(m0_w_ready), .m0_axi_w_valid_o(m0_w_valid), .m0_axi_w_data_o(m0_w_data),
    .m0_axi_w_strb_o(m0_w_strb),
    .m0_axi_b_ready_o(m0_b_ready), .m0_axi_b_valid_i(m0_b_valid), .m0_axi_b_resp_i(m0_b_resp),
    .m0_axi_ar_ready_i(m0_ar_ready), .m0_axi_ar_valid_o(m0_ar_valid), .m0_axi_ar_addr_o(m0_ar_addr),
    .m0_axi_r_ready_o(m0_r_ready), .m0_axi_r_valid_i(m0_r_valid), .m0_axi_r_resp_i(m0_r_resp),
    .m0_axi_r_data_i(m0_r_data),
    .m1_axi_aw_ready_i(m1_aw_ready), .m1_axi_aw_valid_o(m1_aw_valid), .m1_axi_aw_addr_o(m1_aw_addr),
    .m1_axi_w_ready_i(m1_w_ready), .m1_axi_w_valid_o(m1_w_valid), .m1_axi_w_data_o(m1_w_data),
    .m1_axi_w_strb_o(m1_w_strb),
    .m1_axi_b_ready_o(m1_b_ready), .m1_axi_b_valid_i(m1_b_valid), .m1_axi_b_resp_i(m1_b_resp),
    .m1_axi_ar_ready_i(m1_ar_ready), .m1_axi_ar_valid_o(m1_ar_valid), .m1_axi_ar_addr_o(m1_ar_addr),
    .m1_axi_r_ready_o(m1_r_ready), .m1_axi_r_valid_i(m1_r_valid), .m1_axi_r_resp_i(m1_r_resp),
    .m1_axi_r_data_i(m1_r_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_r(input string tag);
    rbeat_t e;
    checks++;
    assert (exp_r_q.size() != 0) else begin
      errors++;
      $error("FAIL %s: observed unexpected r beat expected none", tag);
    end
    if (exp_r_q.size() != 0) begin
      e = exp_r_q.pop_front();
      chk({tag, "_valid"}, 64'(s_r_valid), 64'd1);
      chk({tag, "_data"}, s_r_data, e.data);
      chk({tag, "_resp"}, 64'(s_r_resp), 64'(e.resp));
    end
  endtask

  task automatic pop_b(input string tag);
    logic [1:0] e;
    checks++;
    assert (exp_b_q.size() != 0) else begin
      errors++;
      $error("FAIL %s: observed unexpected b beat expected none", tag);
    end
    if (exp_b_q.size() != 0) begin
      e = exp_b_q.pop_front();
      chk({tag, "_valid"}, 64'(s_b_valid), 64'd1);
      chk({tag, "_resp"}, 64'(s_b_resp), 64'(e));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    s_aw_valid = 0; s_aw_addr = '0; s_w_valid = 0; s_w_data = '0; s_w_strb = '0; s_b_ready = 0;
    s_ar_valid = 0; s_ar_addr = '0; s_r_ready = 0;
    m0_aw_ready = 0; m0_w_ready = 0; m0_b_valid = 0; m0_b_resp = 0;
    m0_ar_ready = 0; m0_r_valid = 0; m0_r_resp = 0; m0_r_data = '0;
    m1_aw_ready = 0; m1_w_ready = 0; m1_b_valid = 0; m1_b_resp = 0;
    m1_ar_ready = 0; m1_r_valid = 0; m1_r_resp = 0; m1_r_data = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    s_ar_valid = 1; s_ar_addr = 64'h8000_0000; m0_ar_ready = 1;
    s_aw_valid = 1; s_aw_addr = 64'h0200_0000; m1_aw_ready = 1;
    repeat (2) tick();
    settle();
    chk("rst_s_ar_ready", 64'(s_ar_ready), 64'd0);
    chk("rst_m0_ar_valid", 64'(m0_ar_valid), 64'd0);
    chk("rst_m1_aw_valid", 64'(m1_aw_valid), 64'd0);
    chk("rst_s_r_valid", 64'(s_r_valid), 64'd0);
    chk("rst_s_b_valid", 64'(s_b_valid), 64'd0);
    clear_inputs();
    rst = 1'b0;
    tick();

    // Window boundaries, checked combinationally without completing a handshake.
    s_ar_valid = 1; s_ar_addr = 64'h0200_FFFF; settle();
    chk("dec_dev_last", 64'(m1_ar_valid), 64'd1);
    s_ar_addr = 64'h0201_0000; #1;
    chk("dec_dev_past_m1", 64'(m1_ar_valid), 64'd0);
    chk("dec_dev_past_err", 64'(s_ar_ready), 64'd1);
    s_ar_addr = 64'h87FF_FFFF; #1;
    chk("dec_mem_last", 64'(m0_ar_valid), 64'd1);
    s_ar_addr = 64'h8800_0000; #1;
    chk("dec_mem_past_m0", 64'(m0_ar_valid), 64'd0);
    chk("dec_mem_past_err", 64'(s_ar_ready), 64'd1);
    s_ar_valid = 0;
    tick();

    // Read to memory with a stalling target.
    s_ar_valid = 1; s_ar_addr = 64'h8000_0010;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t1_m0_ar_valid", 64'(m0_ar_valid), 64'd1);
      chk("t1_s_ar_ready", 64'(s_ar_ready), 64'd0);
      chk("t1_m1_ar_valid", 64'(m1_ar_valid), 64'd0);
      tick();
    end
    m0_ar_ready = 1; settle();
    chk("t1_ar_addr", m0_ar_addr, 64'h8000_0010);
    chk("t1_s_ar_ready_hs", 64'(s_ar_ready), 64'd1);
    exp_r_q.push_back('{64'hDEAD_BEEF_0000_0001, 2'b00});
    tick();
    settle();
    chk("t1_busy_ar_ready", 64'(s_ar_ready), 64'd0);
    chk("t1_busy_ar_fwd", 64'(m0_ar_valid), 64'd0);
    s_ar_valid = 0; m0_ar_ready = 0;
    m0_r_valid = 1; m0_r_data = 64'hDEAD_BEEF_0000_0001; m0_r_resp = 2'b00;
    m1_r_valid = 1; m1_r_data = 64'h5555_5555_5555_5555; m1_r_resp = 2'b11;
    s_r_ready = 1; settle();
    chk("t1_m0_r_ready", 64'(m0_r_ready), 64'd1);
    chk("t1_m1_r_ready", 64'(m1_r_ready), 64'd0);
    pop_r("t1_r");
    tick();
    clear_inputs(); settle();
    chk("t1_idle_r_valid", 64'(s_r_valid), 64'd0);
    tick();

    // Read to device with upstream back-pressure.
    s_ar_valid = 1; s_ar_addr = 64'h0200_BFF8; m1_ar_ready = 1; settle();
    chk("t2_m1_ar_valid", 64'(m1_ar_valid), 64'd1);
    chk("t2_m0_ar_valid", 64'(m0_ar_valid), 64'd0);
    chk("t2_s_ar_ready", 64'(s_ar_ready), 64'd1);
    tick();
    clear_inputs();
    m1_r_valid = 1; m1_r_data = 64'h0123_4567_89AB_CDEF; m1_r_resp = 2'b00;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("t2_m1_r_ready_low", 64'(m1_r_ready), 64'd0);
      chk("t2_s_r_valid_hold", 64'(s_r_valid), 64'd1);
      tick();
    end
    s_r_ready = 1;
    exp_r_q.push_back('{64'h0123_4567_89AB_CDEF, 2'b00});
    settle();
    chk("t2_m1_r_ready", 64'(m1_r_ready), 64'd1);
    pop_r("t2_r");
    tick();
    clear_inputs();

    // Unmapped read.
    s_ar_valid = 1; s_ar_addr = 64'h1000_0000; settle();
    chk("t3_ar_ready", 64'(s_ar_ready), 64'd1);
    chk("t3_m0_ar_valid", 64'(m0_ar_valid), 64'd0);
    chk("t3_m1_ar_valid", 64'(m1_ar_valid), 64'd0);
    exp_r_q.push_back('{64'h0, 2'b11});
    tick();
    clear_inputs();
    s_r_ready = 1;
    m0_r_valid = 1; m0_r_data = 64'hFFFF_0000_FFFF_0000;
    settle();
    pop_r("t3_r");
    tick();
    clear_inputs();

    // Unmapped write near the top of the address space.
    s_aw_valid = 1; s_aw_addr = 64'hFFFF_FFFF_FFFF_FFF0; settle();
    chk("t3_aw_ready", 64'(s_aw_ready), 64'd1);
    chk("t3_m0_aw_valid", 64'(m0_aw_valid), 64'd0);
    chk("t3_m1_aw_valid", 64'(m1_aw_valid), 64'd0);
    tick();
    clear_inputs();
    s_w_valid = 1; s_w_data = 64'hABCD; s_w_strb = 8'hFF; settle();
    chk("t3_w_ready", 64'(s_w_ready), 64'd1);
    chk("t3_m0_w_valid", 64'(m0_w_valid), 64'd0);
    chk("t3_m1_w_valid", 64'(m1_w_valid), 64'd0);
    tick();
    clear_inputs();
    s_b_ready = 1; exp_b_q.push_back(2'b11); settle();
    pop_b("t3_b");
    tick();
    clear_inputs(); settle();
    chk("t3_idle_b_valid", 64'(s_b_valid), 64'd0);
    tick();

    // Write to memory.
    s_aw_valid = 1; s_aw_addr = 64'h8000_0100; m0_aw_ready = 1;
    s_w_valid = 1; s_w_data = 64'h1122_3344_5566_7788; s_w_strb = 8'h0F; m0_w_ready = 1;
    settle();
    chk("t4_m0_aw_valid", 64'(m0_aw_valid), 64'd1);
    chk("t4_m0_aw_addr", m0_aw_addr, 64'h8000_0100);
    chk("t4_s_aw_ready", 64'(s_aw_ready), 64'd1);
    chk("t4_idle_w_ready", 64'(s_w_ready), 64'd0);
    chk("t4_idle_m0_w_valid", 64'(m0_w_valid), 64'd0);
    tick();
    s_aw_valid = 0; m0_aw_ready = 0; settle();
    chk("t4_m0_w_valid", 64'(m0_w_valid), 64'd1);
    chk("t4_m0_w_data", m0_w_data, 64'h1122_3344_5566_7788);
    chk("t4_m0_w_strb", 64'(m0_w_strb), 64'h0F);
    chk("t4_m1_w_valid", 64'(m1_w_valid), 64'd0);
    chk("t4_s_w_ready", 64'(s_w_ready), 64'd1);
    tick();
    clear_inputs();
    m0_b_valid = 1; m0_b_resp = 2'b00; m1_b_valid = 1; m1_b_resp = 2'b10;
    s_b_ready = 1; exp_b_q.push_back(2'b00); settle();
    chk("t4_m0_b_ready", 64'(m0_b_ready), 64'd1);
    chk("t4_m1_b_ready", 64'(m1_b_ready), 64'd0);
    pop_b("t4_b");
    tick();
    clear_inputs();

    // Concurrent read to device and write to memory.
    s_ar_valid = 1; s_ar_addr = 64'h0200_0000; m1_ar_ready = 1;
    s_aw_valid = 1; s_aw_addr = 64'h8000_0000; m0_aw_ready = 1;
    settle();
    chk("t5_m1_ar_valid", 64'(m1_ar_valid), 64'd1);
    chk("t5_m0_ar_valid", 64'(m0_ar_valid), 64'd0);
    chk("t5_m0_aw_valid", 64'(m0_aw_valid), 64'd1);
    chk("t5_m1_aw_valid", 64'(m1_aw_valid), 64'd0);
    tick();
    clear_inputs();
    s_w_valid = 1; s_w_data = 64'h0F0F_0F0F_0F0F_0F0F; s_w_strb = 8'hF0; m0_w_ready = 1;
    m1_r_valid = 1; m1_r_data = 64'hCAFE_F00D_0000_0002; m1_r_resp = 2'b00; s_r_ready = 1;
    exp_r_q.push_back('{64'hCAFE_F00D_0000_0002, 2'b00});
    settle();
    chk("t5_m0_w_valid", 64'(m0_w_valid), 64'd1);
    chk("t5_m0_w_data", m0_w_data, 64'h0F0F_0F0F_0F0F_0F0F);
    chk("t5_s_w_ready", 64'(s_w_ready), 64'd1);
    pop_r("t5_r");
    tick();
    clear_inputs();
    m0_b_valid = 1; m0_b_resp = 2'b01; s_b_ready = 1; exp_b_q.push_back(2'b01); settle();
    pop_b("t5_b");
    tick();
    clear_inputs();

    // Asynchronous reset in the middle of a device read.
    s_ar_valid = 1; s_ar_addr = 64'h0200_0010; m1_ar_ready = 1;
    tick();
    clear_inputs();
    m1_r_valid = 1; m1_r_data = 64'h7777; settle();
    chk("t6_busy_r_valid", 64'(s_r_valid), 64'd1);
    rst = 1'b1; #1;
    chk("t6_rst_r_valid", 64'(s_r_valid), 64'd0);
    chk("t6_rst_m1_r_ready", 64'(m1_r_ready), 64'd0);
    chk("t6_rst_ar_ready", 64'(s_ar_ready), 64'd0);
    tick();
    rst = 1'b0;
    clear_inputs();
    s_ar_valid = 1; s_ar_addr = 64'h8000_0000; m0_ar_ready = 1; settle();
    chk("t6_m0_ar_valid", 64'(m0_ar_valid), 64'd1);
    chk("t6_m1_ar_valid", 64'(m1_ar_valid), 64'd0);
    chk("t6_s_ar_ready", 64'(s_ar_ready), 64'd1);
    tick();
    clear_inputs();
    m0_r_valid = 1; m0_r_data = 64'h8888_0000_8888_0000; m0_r_resp = 2'b00;
    m1_r_valid = 1; m1_r_data = 64'h1;
    s_r_ready = 1;
    exp_r_q.push_back('{64'h8888_0000_8888_0000, 2'b00});
    settle();
    pop_r("t6_r");
    tick();
    clear_inputs();

    chk("leftover_r", 64'(exp_r_q.size()), 64'd0);
    chk("leftover_b", 64'(exp_b_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050133_axi_router.md
Name: ysyx_22050133_axi_router

Overview:
Address-decoding 1-to-2 AXI router between the IFU/LSU arbiter's master port and two downstream targets.
- Target m0 is main memory (SRAM); target m1 is the CLINT/device region.
- Addresses that hit neither window are answered internally with a DECERR response.
- Read and write paths are independent. Each path allows one outstanding transaction; the route is latched at the address handshake.

Parameters:
- AXI_DATA_WIDTH, 64, data bus width.
- AXI_ADDR_WIDTH, 64, address bus width.
- MEM_BASE, 64'h8000_0000, m0 window base.
- MEM_SIZE, 64'h0800_0000, m0 window size in bytes.
- DEV_BASE, 64'h0200_0000, m1 window base.
- DEV_SIZE, 64'h0001_0000, m1 window size in bytes.

Ports:
Each channel group below is a bundle of the listed signals.
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_axi_aw_{valid_i,ready_o,addr_i}  in/out/in  1/1/AW  upstream write address.
- s_axi_w_{valid_i,ready_o,data_i,strb_i}  in/out/in/in  1/1/DW/DW/8  upstream write data.
- s_axi_b_{ready_i,valid_o,resp_o}  in/out/out  1/1/2  upstream write response.
- s_axi_ar_{valid_i,ready_o,addr_i}  in/out/in  1/1/AW  upstream read address.
- s_axi_r_{ready_i,valid_o,resp_o,data_o}  in/out/out/out  1/1/2/DW  upstream read data.
- m0_axi_aw_{ready_i,valid_o,addr_o}  in/out/out  1/1/AW  memory write address.
- m0_axi_w_{ready_i,valid_o,data_o,strb_o}  in/out/out/out  1/1/DW/DW/8  memory write data.
- m0_axi_b_{ready_o,valid_i,resp_i}  out/in/in  1/1/2  memory write response.
- m0_axi_ar_{ready_i,valid_o,addr_o}  in/out/out  1/1/AW  memory read address.
- m0_axi_r_{ready_o,valid_i,resp_i,data_i}  out/in/in/in  1/1/2/DW  memory read data.
- m1_axi_*  same shape as m0_axi_*  device port.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high. Reset forces both FSMs to IDLE and both sel registers to 0. While rst=1, every valid/ready output is 0. Address and data outputs are don't-care, but m*_*_data and resp are driven 0.
- Decode (combinational, unsigned AW-bit arithmetic):
  - hit_dev = (addr >= DEV_BASE) && (addr - DEV_BASE < DEV_SIZE).
  - hit_mem is the same test against MEM_BASE/MEM_SIZE.
  - hit_dev wins if windows overlap.
  - Neither hits gives ERR.
  - Subtract-then-compare prevents overflow at the top of the address space.
- Read FSM (states R_IDLE, R_BUSY; rsel in {M0, M1, ERR}):
  - R_IDLE, M0/M1 decode: forward ar_valid/addr only to the decoded target. s_axi_ar_ready_o = that target's ar_ready. The handshake latches rsel and moves to R_BUSY.
  - R_IDLE, ERR decode: s_axi_ar_ready_o = 1. The handshake latches rsel=ERR and moves to R_BUSY.
  - R_BUSY: s_axi_ar_ready_o = 0 and no ar_valid is forwarded.
    - rsel M0/M1: r channel routed from target rsel; the other target's r_ready = 0.
    - rsel ERR: s_axi_r_valid_o = 1, resp = 2'b11, data = 0.
  - The s_axi_r handshake (valid & ready) returns the FSM to R_IDLE.
  - Zero added latency: combinational pass-through. AR-accept to IDLE takes at least 1 cycle.
- Write FSM (states W_IDLE, W_DATA, W_RESP; wsel latched at the AW handshake):
  - W_IDLE: AW handled exactly as AR above. s_axi_w_ready_o = 0 in W_IDLE.
  - W_DATA: W forwarded to wsel. For ERR, s_axi_w_ready_o = 1 and the data is discarded. The W handshake moves to W_RESP.
  - W_RESP: B routed from wsel. For ERR, b_valid = 1 and resp = 2'b11. The B handshake returns to W_IDLE.
- Concurrency:
  - Read and write FSMs are fully independent.
  - A simultaneous read to m1 and write to m0 proceeds in parallel.
  - Same-target concurrent read and write are both forwarded; the target orders them.
- Signal handling:
  - Unselected target valid outputs are always 0.
  - Upstream valid/resp/data from an unselected target are ignored.
  - The upstream address must stay stable while valid (AXI rule). The router does not re-decode after the handshake.
- Reset mid-transaction drops the transaction silently. Downstream targets are on the same reset.

Decomposition:
- Shared package: AXI resp constants (OKAY 2'b00, DECERR 2'b11), target-select encoding (SEL_M0, SEL_M1, SEL_ERR), FSM state encodings.
- One natural sub-module, ysyx_22050133_addr_decode, is a purely combinational addr→sel decoder. It is instantiated twice, once for AR and once for AW.

Test Plan:
1. Read to memory: AR addr 0x8000_0010 with m0 ar_ready held low 3 cycles → m0_ar_valid=1 and s_ar_ready=0 for those cycles, m1 untouched. m0 returns data 0xDEAD_BEEF_0000_0001, resp 0 → upstream receives it unchanged.
2. Read to device: AR 0x0200_BFF8 → routed to m1 only. r_ready held low 2 cycles → m1_r_ready=0 for 2 cycles and s_r_valid stays 1.
3. Unmapped read at 0x1000_0000 and unmapped write at 0xFFFF_FFFF_FFFF_FFF0:
   - Read: AR accepted the same cycle; r resp 2'b11, data 0.
   - Write: w accepted and discarded; b resp 2'b11. Neither m0 nor m1 sees any valid.
4. Write to memory: addr 0x8000_0100, data 0x1122_3344_5566_7788, strb 0x0F → m0 sees AW, then W with identical data/strb, then B resp 0 forwarded upstream.
5. Concurrency: AR to 0x0200_0000 and AW/W to 0x8000_0000 in the same cycle → both complete independently with correct routing.
6. Async reset asserted mid-cycle during R_BUSY with rsel=M1 → all valid/ready outputs go 0 immediately. After deassert, a new read to 0x8000_0000 routes to m0.
